// File: rtl/hidden_mac_seq_if.sv
// Result stream of the hidden-layer MAC engine: one saturated result per neuron,
// moved with a valid/ready handshake. The master (the engine) holds y_data and y_idx
// stable while y_valid is high and y_ready is low.
interface hidden_mac_seq_if #(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned IDX_W  = 6
) ();
    logic              y_valid;
    logic              y_ready;
    logic [DATA_W-1:0] y_data;
    logic [IDX_W-1:0]  y_idx;

    modport master (
        output y_valid,
        output y_data,
        output y_idx,
        input  y_ready
    );

    modport slave (
        input  y_valid,
        input  y_data,
        input  y_idx,
        output y_ready
    );
endinterface

// File: rtl/hidden_mac_seq.sv
// Sequential hidden-layer MAC engine. For each neuron h it streams W[h][i] and x[i]
// out of two registered-read memories, accumulates the full-precision products,
// rescales the sum by FRAC_W, saturates it to DATA_W bits and offers it on the result
// stream. Optional feature: define HIDDEN_MAC_RELU_EN to clamp negative results to 0.
module hidden_mac_seq #(
    parameter int unsigned DATA_W   = 16,
    parameter int unsigned FRAC_W   = 8,
    parameter int unsigned N_IN     = 128,
    parameter int unsigned N_HIDDEN = 64,
    localparam int unsigned ACC_W    = 2 * DATA_W + $clog2(N_IN),
    localparam int unsigned W_ADDR_W = (N_HIDDEN * N_IN > 1) ? $clog2(N_HIDDEN * N_IN) : 1,
    localparam int unsigned X_ADDR_W = (N_IN > 1) ? $clog2(N_IN) : 1,
    localparam int unsigned IDX_W    = (N_HIDDEN > 1) ? $clog2(N_HIDDEN) : 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start,
    output logic                busy,
    output logic                done,
    output logic [W_ADDR_W-1:0] w_raddr,
    input  logic [DATA_W-1:0]   w_rdata,
    output logic [X_ADDR_W-1:0] x_raddr,
    input  logic [DATA_W-1:0]   x_rdata,
    hidden_mac_seq_if.master    y
);

    typedef enum logic [2:0] {StIdle, StRun, StDrain, StOut, StDone} state_e;

    localparam logic [X_ADDR_W-1:0] LastI = X_ADDR_W'(N_IN - 1);
    localparam logic [IDX_W-1:0]    LastH = IDX_W'(N_HIDDEN - 1);
    localparam logic signed [ACC_W-1:0] SatMax =
        {{(ACC_W - DATA_W + 1){1'b0}}, {(DATA_W - 1){1'b1}}};
    localparam logic signed [ACC_W-1:0] SatMin =
        {{(ACC_W - DATA_W + 1){1'b1}}, {(DATA_W - 1){1'b0}}};

    state_e                    state_q, state_d;
    logic [IDX_W-1:0]          h_cnt_q, h_cnt_d;
    logic [X_ADDR_W-1:0]       i_cnt_q, i_cnt_d;
    logic [W_ADDR_W-1:0]       w_ptr_q, w_ptr_d;
    logic [W_ADDR_W-1:0]       w_raddr_q, w_raddr_d;
    logic [X_ADDR_W-1:0]       x_raddr_q, x_raddr_d;
    logic                      rd_vld_q, rd_vld_d;
    logic signed [ACC_W-1:0]   acc_q, acc_d;
    logic [DATA_W-1:0]         y_data_q, y_data_d;
    logic [IDX_W-1:0]          y_idx_q, y_idx_d;

    logic signed [2*DATA_W-1:0] prod;
    logic signed [ACC_W-1:0]    acc_sum;
    logic signed [ACC_W-1:0]    acc_shift;
    logic [DATA_W-1:0]          y_sat;

    // Includes the product in flight so the DRAIN cycle can register the final result.
    assign prod      = $signed(w_rdata) * $signed(x_rdata);
    assign acc_sum   = acc_q + ACC_W'(prod);
    assign acc_shift = acc_sum >>> FRAC_W;

    // Rescaled sum clamped to the output range, optionally rectified.
    always_comb begin
        y_sat = acc_shift[DATA_W-1:0];
        if (acc_shift > SatMax) begin
            y_sat = {1'b0, {(DATA_W - 1){1'b1}}};
        end else if (acc_shift < SatMin) begin
            y_sat = {1'b1, {(DATA_W - 1){1'b0}}};
        end
`ifdef HIDDEN_MAC_RELU_EN
        if (y_sat[DATA_W-1]) begin
            y_sat = '0;
        end
`else
`endif
    end

    // Next-state logic for the FSM and datapath registers.
    always_comb begin
        state_d   = state_q;
        h_cnt_d   = h_cnt_q;
        i_cnt_d   = i_cnt_q;
        w_ptr_d   = w_ptr_q;
        w_raddr_d = w_raddr_q;
        x_raddr_d = x_raddr_q;
        rd_vld_d  = rd_vld_q;
        acc_d     = rd_vld_q ? acc_sum : acc_q;
        y_data_d  = y_data_q;
        y_idx_d   = y_idx_q;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    h_cnt_d   = '0;
                    i_cnt_d   = '0;
                    w_ptr_d   = '0;
                    w_raddr_d = '0;
                    x_raddr_d = '0;
                    acc_d     = '0;
                    state_d   = StRun;
                end
            end
            StRun: begin
                rd_vld_d = 1'b1;
                // w_ptr runs on past the row end so it already points at the next row.
                w_ptr_d  = w_ptr_q + W_ADDR_W'(1);
                if (i_cnt_q == LastI) begin
                    i_cnt_d = '0;
                    state_d = StDrain;
                end else begin
                    i_cnt_d   = i_cnt_q + X_ADDR_W'(1);
                    x_raddr_d = i_cnt_q + X_ADDR_W'(1);
                    w_raddr_d = w_ptr_q + W_ADDR_W'(1);
                end
            end
            StDrain: begin
                rd_vld_d = 1'b0;
                y_data_d = y_sat;
                y_idx_d  = h_cnt_q;
                state_d  = StOut;
            end
            StOut: begin
                if (y.y_ready) begin
                    if (h_cnt_q == LastH) begin
                        state_d = StDone;
                    end else begin
                        h_cnt_d   = h_cnt_q + IDX_W'(1);
                        acc_d     = '0;
                        w_raddr_d = w_ptr_q;
                        x_raddr_d = '0;
                        state_d   = StRun;
                    end
                end
            end
            StDone: begin
                w_ptr_d = '0;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StIdle;
            h_cnt_q   <= '0;
            i_cnt_q   <= '0;
            w_ptr_q   <= '0;
            w_raddr_q <= '0;
            x_raddr_q <= '0;
            rd_vld_q  <= 1'b0;
            acc_q     <= '0;
            y_data_q  <= '0;
            y_idx_q   <= '0;
        end else begin
            state_q   <= state_d;
            h_cnt_q   <= h_cnt_d;
            i_cnt_q   <= i_cnt_d;
            w_ptr_q   <= w_ptr_d;
            w_raddr_q <= w_raddr_d;
            x_raddr_q <= x_raddr_d;
            rd_vld_q  <= rd_vld_d;
            acc_q     <= acc_d;
            y_data_q  <= y_data_d;
            y_idx_q   <= y_idx_d;
        end
    end

    assign busy      = (state_q != StIdle);
    assign done      = (state_q == StDone);
    assign w_raddr   = w_raddr_q;
    assign x_raddr   = x_raddr_q;
    assign y.y_valid = (state_q == StOut);
    assign y.y_data  = y_data_q;
    assign y.y_idx   = y_idx_q;

endmodule

// File: tb/tb_hidden_mac_seq.sv
// Directed bench for hidden_mac_seq with N_IN=4, N_HIDDEN=2, FRAC_W=8.
module tb_hidden_mac_seq;

    localparam int unsigned DATA_W   = 16;
    localparam int unsigned FRAC_W   = 8;
    localparam int unsigned N_IN     = 4;
    localparam int unsigned N_HIDDEN = 2;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic        busy;
    logic        done;
    logic [2:0]  w_raddr;
    logic [15:0] w_rdata;
    logic [1:0]  x_raddr;
    logic [15:0] x_rdata;

    hidden_mac_seq_if #(.DATA_W(DATA_W), .IDX_W(1)) y_if ();

    hidden_mac_seq #(
        .DATA_W   (DATA_W),
        .FRAC_W   (FRAC_W),
        .N_IN     (N_IN),
        .N_HIDDEN (N_HIDDEN)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .busy    (busy),
        .done    (done),
        .w_raddr (w_raddr),
        .w_rdata (w_rdata),
        .x_raddr (x_raddr),
        .x_rdata (x_rdata),
        .y       (y_if.master)
    );

    always #5 clk = ~clk;

    // Registered-read memories: data appears one cycle after the address.
    logic [15:0] w_mem [8];
    logic [15:0] x_mem [4];
    always @(posedge clk) begin
        w_rdata <= w_mem[w_raddr];
        x_rdata <= x_mem[x_raddr];
    end

    int checks   = 0;
    int failures = 0;

    task automatic check(input string tag, input logic signed [31:0] got,
                         input logic signed [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    function automatic int relu(input int v);
`ifdef HIDDEN_MAC_RELU_EN
        return (v < 0) ? 0 : v;
`else
        return v;
`endif
    endfunction

    task automatic fill(input int wv, input int xv);
        for (int i = 0; i < 8; i++) w_mem[i] = 16'(wv);
        for (int i = 0; i < 4; i++) x_mem[i] = 16'(xv);
    endtask

    // Full layer pass. Cycle k is the interval after edge k-1; start is sampled at edge 0.
    // stall: cycles y_ready is held low at neuron 0. poke: cycle in which start is re-pulsed.
    task automatic do_pass(input string tag, input int exp_y, input int stall, input int poke);
        int valid_cnt = 0;
        int done_cnt  = 0;
        start = 1'b1;
        y_if.y_ready = (stall == 0);
        @(posedge clk); #1;
        start = 1'b0;
        for (int k = 1; k <= 14 + stall; k++) begin
            start = (k == poke);
            y_if.y_ready = (stall == 0) || (k >= 6 + stall);
            if (y_if.y_valid) valid_cnt++;
            if (done) done_cnt++;
            if (k <= 4) begin
                check($sformatf("%s_w_c%0d", tag, k), 32'(w_raddr), k - 1);
                check($sformatf("%s_x_c%0d", tag, k), 32'(x_raddr), k - 1);
            end else if (k == 5) begin
                check($sformatf("%s_whold_c%0d", tag, k), 32'(w_raddr), 3);
                check($sformatf("%s_xhold_c%0d", tag, k), 32'(x_raddr), 3);
                check($sformatf("%s_vld_c%0d", tag, k), 32'(y_if.y_valid), 0);
            end else if (k <= 6 + stall) begin
                check($sformatf("%s_vld_c%0d", tag, k), 32'(y_if.y_valid), 1);
                check($sformatf("%s_y0_c%0d", tag, k), 32'($signed(y_if.y_data)), exp_y);
                check($sformatf("%s_idx0_c%0d", tag, k), 32'(y_if.y_idx), 0);
                check($sformatf("%s_wfrz_c%0d", tag, k), 32'(w_raddr), 3);
                check($sformatf("%s_xfrz_c%0d", tag, k), 32'(x_raddr), 3);
            end else if (k <= 10 + stall) begin
                check($sformatf("%s_w_c%0d", tag, k), 32'(w_raddr), k - 3 - stall);
                check($sformatf("%s_x_c%0d", tag, k), 32'(x_raddr), k - 7 - stall);
            end else if (k == 11 + stall) begin
                check($sformatf("%s_vld_c%0d", tag, k), 32'(y_if.y_valid), 0);
            end else if (k == 12 + stall) begin
                check($sformatf("%s_vld_c%0d", tag, k), 32'(y_if.y_valid), 1);
                check($sformatf("%s_y1_c%0d", tag, k), 32'($signed(y_if.y_data)), exp_y);
                check($sformatf("%s_idx1_c%0d", tag, k), 32'(y_if.y_idx), 1);
            end else if (k == 13 + stall) begin
                check($sformatf("%s_done_c%0d", tag, k), 32'(done), 1);
                check($sformatf("%s_busy_c%0d", tag, k), 32'(busy), 1);
            end else begin
                check($sformatf("%s_idle_busy_c%0d", tag, k), 32'(busy), 0);
                check($sformatf("%s_idle_done_c%0d", tag, k), 32'(done), 0);
            end
            @(posedge clk); #1;
        end
        start = 1'b0;
        y_if.y_ready = 1'b1;
        check($sformatf("%s_valid_cycles", tag), valid_cnt, stall + 2);
        check($sformatf("%s_done_pulses", tag), done_cnt, 1);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int stray;
        rst = 1'b1;
        start = 1'b0;
        y_if.y_ready = 1'b1;
        fill(256, 256);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;

        check("rst_busy", 32'(busy), 0);
        check("rst_done", 32'(done), 0);
        check("rst_valid", 32'(y_if.y_valid), 0);
        check("rst_ydata", 32'(y_if.y_data), 0);
        check("rst_yidx", 32'(y_if.y_idx), 0);
        check("rst_waddr", 32'(w_raddr), 0);
        check("rst_xaddr", 32'(x_raddr), 0);

        do_pass("basic", 1024, 0, 0);
        do_pass("busy_start", 1024, 0, 2);
        do_pass("stall", 1024, 10, 0);

        fill(32767, 32767);
        do_pass("sat_pos", 32767, 0, 0);
        fill(-32768, 32767);
        do_pass("sat_neg", relu(-32768), 0, 0);
        fill(-256, 256);
        do_pass("neg", relu(-1024), 0, 0);

        // Abandon a pass in cycle 3, then confirm a clean restart.
        fill(256, 256);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("mid_busy_before", 32'(busy), 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        check("mid_busy", 32'(busy), 0);
        check("mid_valid", 32'(y_if.y_valid), 0);
        check("mid_done", 32'(done), 0);
        check("mid_waddr", 32'(w_raddr), 0);
        check("mid_xaddr", 32'(x_raddr), 0);
        check("mid_ydata", 32'(y_if.y_data), 0);
        stray = 0;
        for (int k = 0; k < 20; k++) begin
            if (done || y_if.y_valid || busy) stray++;
            @(posedge clk); #1;
        end
        check("mid_quiet", stray, 0);
        do_pass("after_rst", 1024, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
